// File: rtl/rtc_counter_pkg.sv
// Shared field limits and types for the real-time-clock counter.
package rtc_counter_pkg;

  localparam int FIELD_W = 6;

  typedef logic [FIELD_W-1:0] field_t;

  localparam field_t SEC_MAX  = 6'd59;
  localparam field_t MIN_MAX  = 6'd59;
  localparam field_t HOUR_MAX = 6'd23;

  typedef struct packed {
    field_t hour;
    field_t min;
    field_t second;
  } rtc_time_t;

endpackage

// File: rtl/rtc_counter_tick_gen.sv
// One-second prescaler: counts 0..TICK_DIV-1 while enabled, ticks on the last count.
module tick_gen #(
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt == CNT_LAST) cnt <= '0;
      else                 cnt <= cnt + 1'b1;
    end
  end

  assign tick = en && (cnt == CNT_LAST);

endmodule

// File: rtl/rtc_counter.sv
// Hours/minutes/seconds time-of-day counter with preset load and manual adjust.
module rtc_counter
  import rtc_counter_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               load,
  input  logic [FIELD_W-1:0] load_hour,
  input  logic [FIELD_W-1:0] load_min,
  input  logic [FIELD_W-1:0] load_second,
  input  logic               inc_hour,
  input  logic               inc_min,
  output logic [FIELD_W-1:0] hour,
  output logic [FIELD_W-1:0] min,
  output logic [FIELD_W-1:0] second,
  output logic               sec_pulse,
  output logic               min_pulse,
  output logic               day_pulse,
  output logic               load_err
);

  function automatic field_t wrap_inc(input field_t v, input field_t max_v);
    return (v == max_v) ? '0 : field_t'(v + 1'b1);
  endfunction

  logic tick;
  logic load_ok;
  logic load_clr;

  assign load_ok  = (load_hour <= HOUR_MAX) && (load_min <= MIN_MAX) &&
                    (load_second <= SEC_MAX);
  assign load_clr = load && load_ok;

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .clr (load_clr),
    .tick(tick)
  );

  // A tick that lands on a load or manual-adjust cycle is dropped, not deferred.
  always_ff @(posedge clk) begin
    if (rst) begin
      hour      <= '0;
      min       <= '0;
      second    <= '0;
      sec_pulse <= 1'b0;
      min_pulse <= 1'b0;
      day_pulse <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      sec_pulse <= 1'b0;
      min_pulse <= 1'b0;
      day_pulse <= 1'b0;
      load_err  <= 1'b0;
      if (load) begin
        if (load_ok) begin
          hour   <= load_hour;
          min    <= load_min;
          second <= load_second;
        end else begin
          load_err <= 1'b1;
        end
      end else if (inc_hour || inc_min) begin
        if (inc_hour) hour <= wrap_inc(hour, HOUR_MAX);
        if (inc_min)  min  <= wrap_inc(min, MIN_MAX);
      end else if (tick) begin
        second    <= wrap_inc(second, SEC_MAX);
        sec_pulse <= 1'b1;
        if (second == SEC_MAX) begin
          min       <= wrap_inc(min, MIN_MAX);
          min_pulse <= 1'b1;
          if (min == MIN_MAX) begin
            hour <= wrap_inc(hour, HOUR_MAX);
            if (hour == HOUR_MAX) day_pulse <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_rtc_counter.sv
// Scoreboard bench for rtc_counter with TICK_DIV=4 and directed time scenarios.
module tb_rtc_counter;

  logic       clk = 1'b0;
  logic       rst, en, load, inc_hour, inc_min;
  logic [5:0] load_hour, load_min, load_second;
  logic [5:0] hour, min, second;
  logic       sec_pulse, min_pulse, day_pulse, load_err;

  rtc_counter #(.TICK_DIV(4)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load),
    .load_hour(load_hour), .load_min(load_min), .load_second(load_second),
    .inc_hour(inc_hour), .inc_min(inc_min),
    .hour(hour), .min(min), .second(second),
    .sec_pulse(sec_pulse), .min_pulse(min_pulse), .day_pulse(day_pulse),
    .load_err(load_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [5:0] h, m, s;
    logic       sp, mp, dp, le;
    string      tag;
  } exp_t;

  exp_t  q[$];
  exp_t  mon_e;
  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;
  string phase = "";

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int d, input int h, input int m, input int s,
                      input bit sp, input bit mp, input bit dp, input bit le);
    exp_t e;
    e.cyc = cyc + d;
    e.h = 6'(h); e.m = 6'(m); e.s = 6'(s);
    e.sp = sp; e.mp = mp; e.dp = dp; e.le = le;
    e.tag = phase;
    q.push_back(e);
  endtask

  task automatic hold(input int d0, input int d1, input int h, input int m, input int s);
    for (int d = d0; d <= d1; d++) push(d, h, m, s, 0, 0, 0, 0);
  endtask

  task automatic do_load(input int h, input int m, input int s);
    load = 1'b1;
    load_hour = 6'(h); load_min = 6'(m); load_second = 6'(s);
  endtask

  // Monitor: compare outputs against every expectation due this cycle.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      mon_e = q.pop_front();
      checks++;
      if (mon_e.cyc < cyc) begin
        errors++;
        $display("FAIL %s: expectation for cycle %0d never checked (now %0d)", mon_e.tag, mon_e.cyc, cyc);
      end else if ({hour, min, second, sec_pulse, min_pulse, day_pulse, load_err} !==
                   {mon_e.h, mon_e.m, mon_e.s, mon_e.sp, mon_e.mp, mon_e.dp, mon_e.le}) begin
        errors++;
        $display("FAIL %s @cyc %0d: got %0d:%0d:%0d sp=%b mp=%b dp=%b le=%b, expected %0d:%0d:%0d sp=%b mp=%b dp=%b le=%b",
                 mon_e.tag, cyc, hour, min, second, sec_pulse, min_pulse, day_pulse, load_err,
                 mon_e.h, mon_e.m, mon_e.s, mon_e.sp, mon_e.mp, mon_e.dp, mon_e.le);
      end
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0; inc_hour = 1'b0; inc_min = 1'b0;
    load_hour = '0; load_min = '0; load_second = '0;

    phase = "reset";
    tick_clk(); tick_clk();
    push(0, 0, 0, 0, 0, 0, 0, 0);

    phase = "run12";
    rst = 1'b0; en = 1'b1;
    for (int i = 1; i <= 12; i++) push(i, 0, 0, i / 4, (i % 4 == 0), 0, 0, 0);
    repeat (12) tick_clk();
    en = 1'b0;

    phase = "day_roll";
    do_load(23, 59, 58); push(1, 23, 59, 58, 0, 0, 0, 0); tick_clk();
    load = 1'b0; en = 1'b1;
    hold(1, 3, 23, 59, 58);
    push(4, 23, 59, 59, 1, 0, 0, 0);
    hold(5, 7, 23, 59, 59);
    push(8, 0, 0, 0, 1, 1, 1, 0);
    repeat (8) tick_clk();
    en = 1'b0;

    phase = "load_bad_min";  do_load(10, 60, 0); push(1, 0, 0, 0, 0, 0, 0, 1);   tick_clk();
    phase = "load_good";     do_load(10, 59, 0); push(1, 10, 59, 0, 0, 0, 0, 0); tick_clk();
    phase = "load_bad_hour"; do_load(24, 0, 0);  push(1, 10, 59, 0, 0, 0, 0, 1); tick_clk();
    phase = "load_bad_sec";  do_load(0, 0, 60);  push(1, 10, 59, 0, 0, 0, 0, 1); tick_clk();
    phase = "load_err_clear"; load = 1'b0;       push(1, 10, 59, 0, 0, 0, 0, 0); tick_clk();

    phase = "inc_min_wrap";
    do_load(5, 59, 30); push(1, 5, 59, 30, 0, 0, 0, 0); tick_clk();
    load = 1'b0; inc_min = 1'b1; push(1, 5, 0, 30, 0, 0, 0, 0); tick_clk();
    inc_min = 1'b0;
    phase = "inc_hour_wrap";
    do_load(23, 15, 20); push(1, 23, 15, 20, 0, 0, 0, 0); tick_clk();
    load = 1'b0; inc_hour = 1'b1; push(1, 0, 15, 20, 0, 0, 0, 0); tick_clk();
    inc_hour = 1'b0;
    phase = "inc_both";
    do_load(23, 59, 10); push(1, 23, 59, 10, 0, 0, 0, 0); tick_clk();
    load = 1'b0; inc_hour = 1'b1; inc_min = 1'b1; push(1, 0, 0, 10, 0, 0, 0, 0); tick_clk();
    inc_hour = 1'b0; inc_min = 1'b0; push(1, 0, 0, 10, 0, 0, 0, 0); tick_clk();

    phase = "inc_on_tick";
    en = 1'b1;
    hold(1, 3, 0, 0, 10);
    repeat (3) tick_clk();
    inc_min = 1'b1; push(1, 0, 1, 10, 0, 0, 0, 0); tick_clk();
    inc_min = 1'b0;
    hold(1, 3, 0, 1, 10);
    push(4, 0, 1, 11, 1, 0, 0, 0);
    repeat (4) tick_clk();

    phase = "rst_mid_count";
    do_load(12, 34, 56); push(1, 12, 34, 56, 0, 0, 0, 0); tick_clk();
    load = 1'b0;
    hold(1, 2, 12, 34, 56);
    tick_clk(); tick_clk();
    rst = 1'b1; do_load(1, 2, 3); inc_hour = 1'b1; inc_min = 1'b1;
    push(1, 0, 0, 0, 0, 0, 0, 0); tick_clk();
    rst = 1'b0; load = 1'b0; inc_hour = 1'b0; inc_min = 1'b0; en = 1'b0;
    phase = "en_low_hold";
    hold(1, 20, 0, 0, 0);
    repeat (20) tick_clk();
    phase = "first_tick_after_rst";
    en = 1'b1;
    hold(1, 3, 0, 0, 0);
    push(4, 0, 0, 1, 1, 0, 0, 0);
    repeat (4) tick_clk();
    en = 1'b0;

    for (int n = 0; n < 10 && q.size() > 0; n++) tick_clk();
    if (q.size() > 0) begin
      checks += q.size();
      errors += q.size();
      $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
